seg_scan_display: RTL
=====================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter DIGITS, default 8, SHALL set the number of multiplexed digits (legal 1..8).
REQ-002 Parameter SCAN_DIV, default 1024, SHALL set the clk cycles per digit slot (legal >=2).
REQ-003 Parameter PWM_BITS, default 4, SHALL set the brightness resolution (legal 1..8).
REQ-004 clk  input  1  SHALL be the sole clock; all state on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 data  input  4*DIGITS  SHALL carry hex nibbles; nibble i = data[4i+3:4i] drives digit i.
REQ-007 dp  input  DIGITS  SHALL carry the decimal point per digit, 1 = lit.
REQ-008 load  input  1  SHALL request capture of data/dp.
REQ-009 ready  output  1  SHALL indicate a load will be accepted.
REQ-010 enable  input  1  SHALL gate the display; 0 = all dark.
REQ-011 blank_lz  input  1  SHALL enable leading-zero blanking.
REQ-012 brightness  input  PWM_BITS  SHALL set the on-time duty.
REQ-013 SEG  output  8  SHALL be the active-low cathodes: SEG[0..6] = a..g, SEG[7] = dp.
REQ-014 AN  output  DIGITS  SHALL be the active-low digit enables, AN[i] = digit i.
REQ-015 frame_done  output  1  SHALL pulse one cycle per completed scan frame.

Function
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; terminal count = "tick".
REQ-017 Digit index idx SHALL advance on tick and wrap DIGITS-1 -> 0; frame_done SHALL be 1 in the cycle after the tick that wraps idx.
REQ-018 A free-running PWM counter pwm SHALL count 0..2^PWM_BITS-1 every clk; a digit SHALL be lit only while pwm <= brightness (brightness = max gives full on).
REQ-019 Handshake: when load=1 and ready=1, data/dp SHALL be captured into a shadow register, pending set, and ready=0 from the next cycle.
REQ-020 load while ready=0 SHALL be ignored with no state change.
REQ-021 While pending, on the tick that wraps idx to 0 the shadow SHALL copy to the active register and pending SHALL clear, with ready=1 the following cycle; the display SHALL never mix old and new values within a frame.
REQ-022 Decode SHALL map nibbles 0-F to standard hex glyphs 0-9, A, b, C, d, E, F (active-low), with SEG[7] = ~dp[idx].
REQ-023 With blank_lz=1, digit i>0 SHALL be dark (SEG = 8'hFF) when active nibbles i..DIGITS-1 are all zero and dp[i]=0; digit 0 SHALL never be blanked.
REQ-024 SEG and AN SHALL be registered: one clk latency from idx/pwm/enable to the pins.
REQ-025 Exactly one AN bit SHALL be low when the digit is lit; AN SHALL be all ones when enable=0, blanked, or pwm > brightness.
REQ-026 When enable=0, SEG SHALL be 8'hFF; counters and the handshake SHALL keep running.
REQ-027 With DIGITS=1, idx SHALL remain 0 and frame_done SHALL pulse after every tick.

Reset
REQ-028 rst_n=0 SHALL immediately force: prescaler, idx, pwm = 0; active and shadow registers = 0; pending = 0; ready = 1; AN = all ones; SEG = 8'hFF; frame_done = 0.
REQ-029 Reset mid-operation SHALL discard any pending load; the first lit output SHALL follow the first rising clk edge after rst_n rises.

Verification (DIGITS=4, SCAN_DIV=4, PWM_BITS=2 unless noted)
REQ-030 Reset release, data=16'h0000, brightness=3, enable=1 -> AN walks 1110, 1101, 1011, 0111 every 4 clks; SEG=8'hC0; frame_done pulses every 16 clks.
REQ-031 load data=16'h8888, dp=4'b0001 mid-frame -> ready=0 next cycle; old value held until frame end; then SEG=8'h00 on digit 0 and 8'h80 on the others; ready=1 one cycle after transfer.
REQ-032 Second load while ready=0 with data=16'h1234 -> ignored; displayed value remains 16'h8888.
REQ-033 blank_lz=1, data=16'h0050 -> digits 3 and 2 dark (AN all ones in their slots); digit 1 shows 5 (SEG=8'h92); digit 0 shows 0 (SEG=8'hC0).
REQ-034 brightness=1 -> AN low for 2 of every 4 clks within each slot; enable=0 -> AN all ones and SEG=8'hFF one cycle later.
REQ-035 rst_n pulsed low while pending -> outputs reset asynchronously; after release the display shows 0, ready=1, and the pending value is never displayed.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment hex display driver with PWM brightness, leading-zero
// blanking and a frame-synchronous load handshake.
module seg_scan_display #(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 1024,
   parameter int PWM_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   output logic                  ready,
   input  logic                  enable,
   input  logic                  blank_lz,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [7:0]            SEG,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [PWM_BITS-1:0]   pwm_q, pwm_d;
   logic [4*DIGITS-1:0]   act_data_q, act_data_d, sh_data_q, sh_data_d;
   logic [DIGITS-1:0]     act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
   logic                  pending_q, pending_d;
   logic [7:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  frame_done_q;

   logic                  tick, wrap;
   logic [DIGITS-1:0]     upper_zero;
   logic                  zero_run;
   logic [3:0]            nib;
   logic                  dp_bit, uz_bit, blanked, lit;
   logic [6:0]            glyph;

   assign tick  = (presc_q == PW'(SCAN_DIV - 1));
   assign wrap  = tick && (idx_q == IW'(DIGITS - 1));
   assign ready = ~pending_q;

   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
      pwm_d   = pwm_q + 1'b1;
   end

   // Handshake: a load is taken on any edge where load && ready. The shadow is
   // then held (ready low) until the frame boundary moves it to the active copy.
   always_comb begin
      sh_data_d  = sh_data_q;
      sh_dp_d    = sh_dp_q;
      act_data_d = act_data_q;
      act_dp_d   = act_dp_q;
      pending_d  = pending_q;
      if (load && ready) begin
         sh_data_d = data;
         sh_dp_d   = dp;
         pending_d = 1'b1;
      end else if (pending_q && wrap) begin
         act_data_d = sh_data_q;
         act_dp_d   = sh_dp_q;
         pending_d  = 1'b0;
      end
   end

   // upper_zero[i] is set when nibbles i..DIGITS-1 of the active value are all zero.
   always_comb begin
      zero_run   = 1'b1;
      upper_zero = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run      = zero_run & (act_data_q[4*i +: 4] == 4'h0);
         upper_zero[i] = zero_run;
      end
   end

   always_comb begin
      nib    = '0;
      dp_bit = 1'b0;
      uz_bit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nib    = act_data_q[4*i +: 4];
            dp_bit = act_dp_q[i];
            uz_bit = upper_zero[i];
         end
      end
   end

   always_comb begin
      case (nib)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   end

   // Cathodes are also released whenever the digit is dark to avoid ghosting.
   always_comb begin
      blanked = blank_lz && (idx_q != '0) && uz_bit && !dp_bit;
      lit     = enable && (pwm_q <= brightness) && !blanked;
      an_d    = lit ? ~(DIGITS'(1) << idx_q) : '1;
      seg_d   = lit ? {~dp_bit, glyph} : 8'hFF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         idx_q        <= '0;
         pwm_q        <= '0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
         sh_data_q    <= '0;
         sh_dp_q      <= '0;
         pending_q    <= 1'b0;
         seg_q        <= 8'hFF;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pwm_q        <= pwm_d;
         act_data_q   <= act_data_d;
         act_dp_q     <= act_dp_d;
         sh_data_q    <= sh_data_d;
         sh_dp_q      <= sh_dp_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= wrap;
      end
   end

   assign SEG        = seg_q;
   assign AN         = an_q;
   assign frame_done = frame_done_q;

endmodule
